// File: rtl/lane_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_skid_pkg
// Description : Shared types and the per-lane mode helper for lane_skid_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_skid_pkg;

    // Widest lane the helper handles; narrower lanes are zero-extended.
    localparam int c_LANE_MAX_W = 64;

    typedef logic [c_LANE_MAX_W-1:0] lane_word_t;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        REVERSE = 2'd1,
        BCAST   = 2'd2,
        ZERO    = 2'd3
    } lane_mode_e;

    // Encoding equals the occupancy reported on out_count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic lane_word_t apply_lane_mode(
        input lane_mode_e mode,
        input lane_word_t self_lane,
        input lane_word_t mirror_lane,
        input lane_word_t first_lane
    );
        case (mode)
            PASS:    return self_lane;
            REVERSE: return mirror_lane;
            BCAST:   return first_lane;
            default: return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mode_xform.sv
`default_nettype none
// ============================================================================
// Module      : lane_mode_xform
// Description : Combinational lane transform (pass/reverse/broadcast/zero).
// Revision    : 1.0 - initial release
// ============================================================================
module lane_mode_xform
    import lane_skid_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  lane_mode_e             mode,
    input  logic [0:N-1][W-1:0]    in_data,
    output logic [0:N-1][W-1:0]    out_data
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign out_data[i] = W'(apply_lane_mode(mode,
                                                lane_word_t'(in_data[i]),
                                                lane_word_t'(in_data[N-1-i]),
                                                lane_word_t'(in_data[0])));
    end

endmodule
`default_nettype wire

// File: rtl/lane_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lane_skid_pipe
// Description : N-lane registered stage with mode transform and 2-entry skid
//               buffer. Define LANE_SKID_PIPE_PARITY_EN to add out_par.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_skid_pipe
    import lane_skid_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [1:0]             in_mode,
    input  logic [0:N-1][W-1:0]    in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data [N],
`ifdef LANE_SKID_PIPE_PARITY_EN
    output logic [N-1:0]           out_par,
`endif
    output logic [1:0]             out_count
);

    skid_state_e            r_state;
    skid_state_e            w_state_d;
    logic [0:N-1][W-1:0]    r_main;
    logic [0:N-1][W-1:0]    r_skid;
    logic [0:N-1][W-1:0]    w_xf_data;
    logic [0:N-1][W-1:0]    w_main_d;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_load_main;
    logic                   w_load_skid;
    logic                   w_main_from_skid;

    lane_mode_xform #(
        .N (N),
        .W (W)
    ) u_xform (
        .mode     (lane_mode_e'(in_mode)),
        .in_data  (in_data),
        .out_data (w_xf_data)
    );

    // Ready depends only on registered state and reset, never on out_ready.
    assign in_ready   = (r_state != TWO) && !rst;
    assign out_valid  = (r_state != EMPTY);
    assign out_count  = r_state;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_main_d   = w_main_from_skid ? r_skid : w_xf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_d   = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_d   = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_d = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_state_d        = ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) r_main <= w_main_d;
            if (w_load_skid) r_skid <= w_xf_data;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_data[i] = r_main[i];
    end

`ifdef LANE_SKID_PIPE_PARITY_EN
    logic [N-1:0] r_par;
    logic [N-1:0] w_par_d;

    for (genvar i = 0; i < N; i++) begin : g_par
        assign w_par_d[i] = ^w_main_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= '0;
        end else if (w_load_main) begin
            r_par <= w_par_d;
        end
    end

    assign out_par = r_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_skid_pipe
// Description : Self-checking bench; a 2-deep queue model predicts all outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_skid_pipe;

    localparam int N = 3;
    localparam int W = 8;

    typedef logic [0:N-1][W-1:0] vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [1:0]     in_mode;
    vec_t           in_data;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data [N];
    logic [1:0]     out_count;
`ifdef LANE_SKID_PIPE_PARITY_EN
    logic [N-1:0]   out_par;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    vec_t q[$];

    always #5 clk = ~clk;

    lane_skid_pipe #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef LANE_SKID_PIPE_PARITY_EN
        .out_par   (out_par),
`endif
        .out_count (out_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model_xform(input logic [1:0] mode, input vec_t d);
        vec_t r;
        for (int i = 0; i < N; i++) begin
            case (mode)
                2'd0:    r[i] = d[i];
                2'd1:    r[i] = d[N-1-i];
                2'd2:    r[i] = d[0];
                default: r[i] = '0;
            endcase
        end
        return r;
    endfunction

    // Reference: a FIFO of at most two transformed words.
    always @(posedge clk) begin
        bit exp_rdy;
        bit exp_vld;
        exp_rdy = !rst && (q.size() < 2);
        exp_vld = (q.size() != 0);
        if (rst) begin
            q.delete();
        end else begin
            if (exp_vld && out_ready) void'(q.pop_front());
            if (exp_rdy && in_valid) q.push_back(model_xform(in_mode, in_data));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < 2)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
            chk("out_count", {30'd0, out_count}, q.size());
            if (q.size() != 0) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("out_data[%0d]", i), {24'd0, out_data[i]}, {24'd0, q[0][i]});
`ifdef LANE_SKID_PIPE_PARITY_EN
                    chk($sformatf("out_par[%0d]", i), {31'd0, out_par[i]}, {31'd0, ^q[0][i]});
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lanes(input string name, input logic [W-1:0] e0,
                               input logic [W-1:0] e1, input logic [W-1:0] e2);
        chk({name, "_l0"}, {24'd0, out_data[0]}, {24'd0, e0});
        chk({name, "_l1"}, {24'd0, out_data[1]}, {24'd0, e1});
        chk({name, "_l2"}, {24'd0, out_data[2]}, {24'd0, e2});
    endtask

    task automatic send_one(input logic [1:0] mode, input vec_t d, input string name,
                            input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data   = d;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        check_lanes(name, e0, e1, e2);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {30'd0, out_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_lanes("rst_data", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Mode transforms
        send_one(2'd0, {8'h11, 8'h22, 8'h33}, "pass",  8'h11, 8'h22, 8'h33);
        send_one(2'd1, {8'h11, 8'h22, 8'h33}, "rev",   8'h33, 8'h22, 8'h11);
        send_one(2'd2, {8'h11, 8'h22, 8'h33}, "bcast", 8'h11, 8'h11, 8'h11);
        send_one(2'd3, {8'h11, 8'h22, 8'h33}, "zero",  8'h00, 8'h00, 8'h00);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_data   = {8'haa, 8'hbb, 8'hcc};
        step();
        chk("bp_count1", {30'd0, out_count}, 32'd1);
        in_data = {8'hdd, 8'hee, 8'hff};
        step();
        chk("bp_count2", {30'd0, out_count}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_lanes("bp_hold", 8'haa, 8'hbb, 8'hcc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain1", {30'd0, out_count}, 32'd1);
        check_lanes("bp_b", 8'hdd, 8'hee, 8'hff);
        step();
        chk("bp_drain0", {30'd0, out_count}, 32'd0);

        // Back-to-back streaming
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_mode = 2'($urandom_range(0, 3));
            in_data = vec_t'($urandom);
            step();
            chk("stream_count", {30'd0, out_count}, 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = vec_t'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset while full, with a handshake offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {8'h01, 8'h02, 8'h03};
        repeat (2) step();
        chk("full_count", {30'd0, out_count}, 32'd2);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_count", {30'd0, out_count}, 32'd0);
        check_lanes("midrst_data", 8'h00, 8'h00, 8'h00);
`ifdef LANE_SKID_PIPE_PARITY_EN
        chk("midrst_par", {29'd0, out_par}, 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
`ifdef LANE_SKID_PIPE_PARITY_EN
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_data  = {8'h07, 8'h03, 8'h01};
        step();
        in_valid = 1'b0;
        chk("par_07", {29'd0, out_par}, 32'd5);
        step();
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
